// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, single-outstanding memory read, and a
// valid/ready hand-off of each fetched word. Optional macro FETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [1:0] ST_FAULT = 2'd3;
`endif

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        drop;
   logic [31:0] redirect_target;
   logic        req_fire;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;
   assign redirect_target = redirect_pc;
   assign fetch_fault     = fault_q;
`else
   logic redirect_lsb_unused;
   assign redirect_lsb_unused = |redirect_pc[1:0];
   assign redirect_target     = {redirect_pc[31:2], 2'b00};
   assign fetch_fault         = 1'b0;
`endif

   assign mem_req_valid = (state == ST_REQ) && !drop;
   assign mem_req_addr  = pc_q;
   assign pc            = pc_q;
   assign instr_valid   = (state == ST_HOLD);
   assign instruction   = instr_q;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // Redirect outranks every normal transition; a request already accepted
   // (or in flight) leaves one stale response that the drop flag swallows.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_REQ;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         drop    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q <= 1'b0;
`endif
      end
`ifdef FETCH_ALIGN_CHECK_EN
      else if (state == ST_FAULT) begin
         state <= ST_FAULT;
      end
`endif
      else if (redirect_valid) begin
         pc_q <= redirect_target;
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            state   <= ST_FAULT;
            fault_q <= 1'b1;
            drop    <= 1'b0;
         end else
`endif
         begin
            case (state)
               ST_REQ: begin
                  if (req_fire) begin
                     state <= ST_WAIT;
                     drop  <= 1'b1;
                  end else begin
                     state <= ST_REQ;
                  end
               end
               ST_WAIT: begin
                  if (mem_rsp_valid) begin
                     state <= ST_REQ;
                     drop  <= 1'b0;
                  end else begin
                     state <= ST_WAIT;
                     drop  <= 1'b1;
                  end
               end
               default: begin
                  state <= ST_REQ;
                  drop  <= 1'b0;
               end
            endcase
         end
      end else begin
         case (state)
            ST_REQ: begin
               if (req_fire) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= ST_REQ;
                  end else begin
                     instr_q <= mem_rsp_data;
                     state   <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  pc_q  <= pc_q + 32'd4;
                  state <= ST_REQ;
               end
            end
            default: begin
               state <= ST_REQ;
               drop  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch; honours FETCH_ALIGN_CHECK_EN when defined.
module tb_instruction_fetch;

   logic        clk;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int          checks;
   int          errors;
   logic        auto_mem;
   logic [31:0] mem_word;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk),
      .rst(rst),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instruction(instruction),
      .pc(pc),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .fetch_fault(fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock; a memory that answers one cycle after acceptance when auto_mem is set.
   task automatic step();
      logic accepted;
      accepted = mem_req_valid && mem_req_ready;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (auto_mem && accepted) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word;
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = 32'h0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      auto_mem       = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_valid got %b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 00000000", mem_req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid got %b want 0", instr_valid); end
      checks++; if (instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_instruction got %h want 00000013", instruction); end
      checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b want 0", fetch_fault); end
   endtask

   task automatic test_fetch_and_stall();
      do_reset();
      mem_req_ready = 1'b1;
      auto_mem      = 1'b1;
      mem_word      = 32'h00C0_0293;
      step();
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_req_valid got %b want 0", mem_req_valid); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_instr_valid got %b want 0", instr_valid); end
      step();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_instr_valid got %b want 1", instr_valid); end
      checks++; if (instruction !== 32'h00C0_0293) begin errors++; $display("[TB] FAIL hold_instruction got %h want 00c00293", instruction); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (instr_valid !== 1'b1 || instruction !== 32'h00C0_0293 || mem_req_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL stall_%0d got v=%b i=%h r=%b want v=1 i=00c00293 r=0", i, instr_valid, instruction, mem_req_valid); end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      checks++; if (pc !== 32'h4) begin errors++; $display("[TB] FAIL consume_pc got %h want 00000004", pc); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin errors++; $display("[TB] FAIL next_req got v=%b a=%h want v=1 a=00000004", mem_req_valid, mem_req_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL consume_instr_valid got %b want 0", instr_valid); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      checks++; if (pc !== 32'h100 || mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_redirect got pc=%h r=%b want pc=00000100 r=0", pc, mem_req_valid); end
      step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      step();
      checks++; if (instr_valid !== 1'b0 || instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL stale_dropped got v=%b i=%h want v=0 i=00000013", instr_valid, instruction); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL stale_next_req got v=%b a=%h want v=1 a=00000100", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      auto_mem      = 1'b1;
      mem_word      = 32'h1234_5678;
      step();
      step();
      checks++; if (instr_valid !== 1'b1 || instruction !== 32'h1234_5678) begin errors++; $display("[TB] FAIL after_drop_fetch got v=%b i=%h want v=1 i=12345678", instr_valid, instruction); end
   endtask

   task automatic test_redirect_hold();
      do_reset();
      mem_req_ready = 1'b1;
      auto_mem      = 1'b1;
      mem_word      = 32'h1111_1111;
      step();
      step();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_redirect_hold got %b want 1", instr_valid); end
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_redirect_valid got %b want 0", instr_valid); end
      checks++; if (pc !== 32'h40 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin errors++; $display("[TB] FAIL hold_redirect_req got pc=%h v=%b a=%h want 00000040 1 00000040", pc, mem_req_valid, mem_req_addr); end
   endtask

   task automatic test_redirect_req();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      step();
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80) begin errors++; $display("[TB] FAIL retarget got v=%b a=%h want v=1 a=00000080", mem_req_valid, mem_req_addr); end
      mem_req_ready  = 1'b1;
      auto_mem       = 1'b1;
      mem_word       = 32'hAAAA_5555;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      step();
      redirect_valid = 1'b0;
      mem_req_ready  = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || pc !== 32'h20) begin errors++; $display("[TB] FAIL accept_redirect got v=%b pc=%h want v=0 pc=00000020", mem_req_valid, pc); end
      step();
      checks++; if (instr_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h20) begin errors++; $display("[TB] FAIL accept_redirect_drop got iv=%b v=%b a=%h want 0 1 00000020", instr_valid, mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h60;
      step();
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h60 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsp_redirect got v=%b a=%h iv=%b want 1 00000060 0", mem_req_valid, mem_req_addr, instr_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      mem_req_ready  = 1'b1;
      auto_mem       = 1'b1;
      mem_word       = 32'h0000_0073;
      step();
      step();
      checks++; if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_hold got v=%b pc=%h want 1 fffffffc", instr_valid, pc); end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      checks++; if (pc !== 32'h0 || mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h want 00000000", pc); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      mem_req_ready = 1'b1;
      auto_mem      = 1'b1;
      mem_word      = 32'h2222_3333;
      step();
      step();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      auto_mem    = 1'b0;
      step();
      mem_req_ready = 1'b0;
      rst           = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (pc !== 32'h0 || instr_valid !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_reset got pc=%h iv=%b v=%b want 00000000 0 1", pc, instr_valid, mem_req_valid); end
      checks++; if (instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL wait_reset_instr got %h want 00000013", instruction); end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBADB_AD00;
      step();
      checks++; if (instr_valid !== 1'b0 || mem_req_valid !== 1'b1 || instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL late_rsp got iv=%b v=%b i=%h want 0 1 00000013", instr_valid, mem_req_valid, instruction); end
   endtask

   task automatic test_misaligned();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      checks++; if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || pc !== 32'h102) begin errors++; $display("[TB] FAIL misalign_fault got f=%b v=%b pc=%h want 1 0 00000102", fetch_fault, mem_req_valid, pc); end
      mem_req_ready  = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_valid = 1'b0;
      step();
      checks++; if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h102) begin errors++; $display("[TB] FAIL fault_sticky got f=%b v=%b iv=%b pc=%h want 1 0 0 00000102", fetch_fault, mem_req_valid, instr_valid, pc); end
      do_reset();
      checks++; if (fetch_fault !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL fault_exit got f=%b v=%b want 0 1", fetch_fault, mem_req_valid); end
`else
      checks++; if (fetch_fault !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL misalign_forced got f=%b v=%b a=%h want 0 1 00000100", fetch_fault, mem_req_valid, mem_req_addr); end
`endif
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      mem_word = 32'h0;
      test_reset();
      test_fetch_and_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_req();
      test_wrap();
      test_reset_in_wait();
      test_misaligned();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
